// File: rtl/accum_act_pkg.sv
// accum_act_pkg: shared widths, limits, the output-FIFO row payload and the
// saturating accumulate helper used by the accumulate/activate unit.
// Optional build macro ACCUM_ACT_RELU_EN is consumed by act_quant, not here.
package accum_act_pkg;

  localparam int unsigned MATRIX_SIZE    = 8;
  localparam int unsigned PARTIAL_SUM_BW = 20;
  localparam int unsigned ACC_BW         = 24;
  localparam int unsigned DATA_BW        = 8;
  localparam int unsigned ACC_ADDR_BW    = 4;
  localparam int unsigned ACC_DEPTH      = 1 << ACC_ADDR_BW;
  localparam int unsigned SHIFT_BW       = 5;
  localparam int unsigned FIFO_DEPTH     = 2;

  localparam logic signed [ACC_BW-1:0]  ACC_MAX  = {1'b0, {(ACC_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0]  ACC_MIN  = {1'b1, {(ACC_BW-1){1'b0}}};
  localparam logic signed [DATA_BW-1:0] DATA_MAX = {1'b0, {(DATA_BW-1){1'b1}}};
  localparam logic signed [DATA_BW-1:0] DATA_MIN = {1'b1, {(DATA_BW-1){1'b0}}};

  // One quantised result row waiting for the output handshake.
  typedef struct packed {
    logic [ACC_ADDR_BW-1:0]         addr;
    logic [DATA_BW*MATRIX_SIZE-1:0] data;
  } out_row_t;

  typedef struct packed {
    logic              sat;
    logic [ACC_BW-1:0] val;
  } acc_sum_t;

  // Signed add clamped to the accumulator range; sat marks a clamp.
  function automatic acc_sum_t acc_add_sat(input logic [ACC_BW-1:0] a,
                                           input logic [ACC_BW-1:0] b);
    logic [ACC_BW:0] w_full;
    acc_sum_t        r;
    w_full = {a[ACC_BW-1], a} + {b[ACC_BW-1], b};
    r.sat  = (w_full[ACC_BW] != w_full[ACC_BW-1]);
    if (!r.sat)            r.val = w_full[ACC_BW-1:0];
    else if (w_full[ACC_BW]) r.val = ACC_MIN;
    else                   r.val = ACC_MAX;
    return r;
  endfunction

endpackage

// File: rtl/accum_act_unit_act_quant.sv
// act_quant: one-lane requantiser. Rounds (adds 1<<(shift-1) for shift>0),
// arithmetic-shifts right, then clamps to the activation range.
// Build macro ACCUM_ACT_RELU_EN: negative results become 0 instead of
// clamping at the signed minimum.
// Ports: i_acc   accumulator value (signed, ACC_BW)
//        i_shift right-shift amount
//        o_act_c quantised activation (signed, DATA_BW), combinational
//        o_sat_c 1 when the value was clamped, combinational
module act_quant
  import accum_act_pkg::*;
(
  input  logic [ACC_BW-1:0]   i_acc,
  input  logic [SHIFT_BW-1:0] i_shift,
  output logic [DATA_BW-1:0]  o_act_c,
  output logic                o_sat_c
);

  // Wide enough that the rounding constant for any shift cannot overflow.
  localparam int unsigned EXT_BW = 64;
  localparam logic signed [EXT_BW-1:0] HI = EXT_BW'(DATA_MAX);
`ifndef ACCUM_ACT_RELU_EN
  localparam logic signed [EXT_BW-1:0] LO = EXT_BW'(DATA_MIN);
`endif

  logic signed [EXT_BW-1:0] w_ext;
  logic signed [EXT_BW-1:0] w_round;
  logic signed [EXT_BW-1:0] w_shifted;

  always_comb begin
    w_ext   = EXT_BW'($signed(i_acc));
    w_round = '0;
    if (i_shift != '0) w_round = EXT_BW'(1) << (i_shift - SHIFT_BW'(1));
    w_shifted = (w_ext + w_round) >>> i_shift;

    o_act_c = w_shifted[DATA_BW-1:0];
    o_sat_c = 1'b0;
    if (w_shifted > HI) begin
      o_act_c = DATA_MAX;
      o_sat_c = 1'b1;
    end
`ifdef ACCUM_ACT_RELU_EN
    else if (w_shifted[EXT_BW-1]) begin
      o_act_c = '0;
    end
`else
    else if (w_shifted < LO) begin
      o_act_c = DATA_MIN;
      o_sat_c = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/accum_act_unit.sv
// accum_act_unit: accumulates partial-sum rows into a row-addressed
// accumulator bank and, on a row's last pass, requantises it and queues the
// activations in a 2-entry output FIFO.
// Build macro ACCUM_ACT_RELU_EN (see act_quant) selects ReLU clamping.
// Ports: clk/rst                 clock, async active-high reset
//        in_valid/in_ready       input row handshake
//        in_row/in_addr          partial sums (8 x s20) and accumulator row
//        in_acc/in_last          accumulate vs overwrite, emit on this pass
//        cfg_shift               requantisation shift, static while busy
//        out_valid/out_ready     output handshake
//        out_data/out_addr       activations (8 x s8) and their row index
//        sat_flag/sat_clr        sticky saturation flag and its clear
module accum_act_unit
  import accum_act_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_row,
  input  logic [ACC_ADDR_BW-1:0]              in_addr,
  input  logic                                in_acc,
  input  logic                                in_last,
  input  logic [SHIFT_BW-1:0]                 cfg_shift,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_BW*MATRIX_SIZE-1:0]      out_data,
  output logic [ACC_ADDR_BW-1:0]              out_addr,
  output logic                                sat_flag,
  input  logic                                sat_clr
);

  localparam int unsigned ROW_ACC_BW = ACC_BW * MATRIX_SIZE;

  logic [ROW_ACC_BW-1:0] r_acc_mem [ACC_DEPTH];

  // Stage 1 registers
  logic                                 r_s1_valid;
  logic                                 r_s1_acc;
  logic                                 r_s1_last;
  logic [ACC_ADDR_BW-1:0]               r_s1_addr;
  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] r_s1_row;
  logic [ROW_ACC_BW-1:0]                r_s1_stored;

  // Output FIFO: head drives the outputs directly, tail is the second slot
  out_row_t   r_head;
  out_row_t   r_tail;
  logic [1:0] r_count;
  logic       r_out_valid;
  logic       r_in_ready;
  logic       r_sat_flag;

  logic                        w_accept;
  logic                        w_fwd;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_inflight_n;
  logic                        w_sat_set;
  logic [1:0]                  w_count_n;
  logic [ROW_ACC_BW-1:0]       w_sum_row;
  logic [MATRIX_SIZE-1:0]      w_acc_sat;
  logic [DATA_BW*MATRIX_SIZE-1:0] w_q_row;
  logic [MATRIX_SIZE-1:0]      w_q_sat;
  out_row_t                    w_push_entry;

  // Stage 2 datapath: per-lane saturating sum and requantisation
  for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_lane
    acc_sum_t w_lane_sum;

    always_comb begin
      w_lane_sum = acc_add_sat(r_s1_acc ? r_s1_stored[c*ACC_BW +: ACC_BW] : ACC_BW'(0),
                               ACC_BW'($signed(r_s1_row[c*PARTIAL_SUM_BW +: PARTIAL_SUM_BW])));
    end

    assign w_sum_row[c*ACC_BW +: ACC_BW] = w_lane_sum.val;
    assign w_acc_sat[c]                  = w_lane_sum.sat;

    act_quant u_act_quant (
      .i_acc   (w_lane_sum.val),
      .i_shift (cfg_shift),
      .o_act_c (w_q_row[c*DATA_BW +: DATA_BW]),
      .o_sat_c (w_q_sat[c])
    );
  end

  // Handshake, forwarding and FIFO occupancy bookkeeping
  always_comb begin
    w_accept     = in_valid & r_in_ready;
    // Row in stage 2 targets the row being read: take its fresh sum
    w_fwd        = r_s1_valid & (r_s1_addr == in_addr);
    w_push       = r_s1_valid & r_s1_last;
    w_pop        = r_out_valid & out_ready;
    w_count_n    = r_count + 2'(w_push) - 2'(w_pop);
    w_inflight_n = w_accept & in_last;
    w_sat_set    = r_s1_valid & ((|w_acc_sat) | (r_s1_last & (|w_q_sat)));
    w_push_entry = '{addr: r_s1_addr, data: w_q_row};
  end

  // Pipeline and accumulator bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ACC_DEPTH; i++) r_acc_mem[i] <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_acc    <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_row    <= '0;
      r_s1_stored <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_acc    <= in_acc;
        r_s1_last   <= in_last;
        r_s1_addr   <= in_addr;
        r_s1_row    <= in_row;
        r_s1_stored <= w_fwd ? w_sum_row : r_acc_mem[in_addr];
      end
      if (r_s1_valid) r_acc_mem[r_s1_addr] <= w_sum_row;
    end
  end

  // Output FIFO, input flow control and sticky saturation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_sat_flag  <= 1'b0;
    end else begin
      r_count     <= w_count_n;
      r_out_valid <= (w_count_n != 2'd0);
      // Queued plus in-flight last rows may never exceed the FIFO depth
      r_in_ready  <= (3'(w_count_n) + 3'(w_inflight_n)) < 3'(FIFO_DEPTH);
      if (w_pop && (r_count == 2'd2)) r_head <= r_tail;
      if (w_push) begin
        if ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)) r_head <= w_push_entry;
        else                                                    r_tail <= w_push_entry;
      end
      r_sat_flag <= w_sat_set | (r_sat_flag & ~sat_clr);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_head.data;
  assign out_addr  = r_head.addr;
  assign sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_accum_act_unit.sv
// tb_accum_act_unit: directed vectors with hand-computed expectations for
// accum_act_unit. Honours ACCUM_ACT_RELU_EN for the negative-input case.
module tb_accum_act_unit;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [159:0] in_row;
  logic [3:0]   in_addr;
  logic         in_acc;
  logic         in_last;
  logic [4:0]   cfg_shift;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic [3:0]   out_addr;
  logic         sat_flag;
  logic         sat_clr;

  int n_cmp = 0;
  int n_mis = 0;

`ifdef ACCUM_ACT_RELU_EN
  localparam logic [7:0] NEG_EXP = 8'h00;
`else
  localparam logic [7:0] NEG_EXP = 8'h80;
`endif

  accum_act_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_addr   (in_addr),
    .in_acc    (in_acc),
    .in_last   (in_last),
    .cfg_shift (cfg_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .sat_flag  (sat_flag),
    .sat_clr   (sat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] mk_row(input logic [19:0] v0, input logic [19:0] vr);
    logic [159:0] row;
    row        = {8{vr}};
    row[19:0]  = v0;
    return row;
  endfunction

  function automatic logic [63:0] mk_out(input logic [7:0] e0, input logic [7:0] er);
    return {{7{er}}, e0};
  endfunction

  // Offer one row; returns 1 time unit after the edge that accepted it.
  task automatic send(input logic [3:0] a, input logic [19:0] v0, input logic [19:0] vr,
                      input logic acc, input logic last);
    int t;
    t        = 0;
    in_row   = mk_row(v0, vr);
    in_addr  = a;
    in_acc   = acc;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check_val("in_ready_at_send", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for a row, check it, then pop it with a one-cycle out_ready pulse.
  task automatic recv(input string tag, input logic [3:0] ea, input logic [7:0] e0,
                      input logic [7:0] er);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_val({tag, "_addr"}, 64'(out_addr), 64'(ea));
    check_val({tag, "_data"}, out_data, mk_out(e0, er));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_row    = '0;
    in_addr   = '0;
    in_acc    = 1'b0;
    in_last   = 1'b0;
    cfg_shift = '0;
    out_ready = 1'b0;
    sat_clr   = 1'b0;

    // Reset state
    #12;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_data", out_data, 64'd0);
    check_val("rst_out_addr", 64'(out_addr), 64'd0);
    check_val("rst_sat_flag", 64'(sat_flag), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Overwrite then accumulate: (100 + 28 + 2) >>> 2 = 32
    cfg_shift = 5'd2;
    send(4'd3, 20'd100, 20'd100, 1'b0, 1'b0);
    send(4'd3, 20'd28, 20'd28, 1'b1, 1'b1);
    check_val("lat_after_accept", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_val("lat_after_stage2", 64'(out_valid), 64'd1);
    recv("ovr_acc", 4'd3, 8'd32, 8'd32);

    // Back-to-back same address: 1 + 2 + 3 = 6
    cfg_shift = 5'd0;
    send(4'd5, 20'd1, 20'd1, 1'b0, 1'b0);
    send(4'd5, 20'd2, 20'd2, 1'b1, 1'b0);
    send(4'd5, 20'd3, 20'd3, 1'b1, 1'b1);
    recv("b2b", 4'd5, 8'd6, 8'd6);

    // Output saturation: 16 x 524287 = 8388592 -> 127
    for (int i = 0; i < 16; i++)
      send(4'd7, 20'd524287, 20'd0, logic'(i != 0), logic'(i == 15));
    recv("sat_out", 4'd7, 8'd127, 8'd0);
    check_val("sat_flag_set", 64'(sat_flag), 64'd1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check_val("sat_flag_clr", 64'(sat_flag), 64'd0);

    // Set beats a simultaneous clear
    sat_clr = 1'b1;
    send(4'd8, 20'd524287, 20'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_val("sat_set_wins", 64'(sat_flag), 64'd1);
    recv("sat_single", 4'd8, 8'd127, 8'd0);
    check_val("sat_clr_held", 64'(sat_flag), 64'd0);
    sat_clr = 1'b0;

    // Accumulator clamp: 17 x 524287 clamps to 8388607; (x + 2^22) >>> 23 = 1
    cfg_shift = 5'd23;
    for (int i = 0; i < 17; i++)
      send(4'd9, 20'd524287, 20'd0, logic'(i != 0), logic'(i == 16));
    recv("acc_sat", 4'd9, 8'd1, 8'd0);
    check_val("acc_sat_flag", 64'(sat_flag), 64'd1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;

    // Negative input: (-300 + 1) >>> 1 = -150 -> clamp; (50 + 1) >>> 1 = 25
    cfg_shift = 5'd1;
    send(4'd10, -20'sd300, 20'd50, 1'b0, 1'b1);
    recv("neg", 4'd10, NEG_EXP, 8'd25);

    // Backpressure: two rows fill the FIFO, third waits
    cfg_shift = 5'd0;
    send(4'd11, 20'd10, 20'd10, 1'b0, 1'b1);
    check_val("bp_ready_1", 64'(in_ready), 64'd1);
    send(4'd12, 20'd20, 20'd20, 1'b0, 1'b1);
    check_val("bp_ready_2", 64'(in_ready), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_val("bp_stall_addr", 64'(out_addr), 64'd11);
    check_val("bp_stall_data", out_data, mk_out(8'd10, 8'd10));
    check_val("bp_stall_ready", 64'(in_ready), 64'd0);
    fork
      send(4'd13, 20'd30, 20'd30, 1'b0, 1'b1);
      begin
        recv("bp_row0", 4'd11, 8'd10, 8'd10);
        recv("bp_row1", 4'd12, 8'd20, 8'd20);
        recv("bp_row2", 4'd13, 8'd30, 8'd30);
      end
    join

    // Reset with two rows queued, then accumulate onto a cleared row
    send(4'd14, 20'd40, 20'd40, 1'b0, 1'b1);
    send(4'd15, 20'd50, 20'd50, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_val("rst_mid_pre", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_val("rst_mid_valid", 64'(out_valid), 64'd0);
    check_val("rst_mid_ready", 64'(in_ready), 64'd1);
    check_val("rst_mid_data", out_data, 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    send(4'd3, 20'd77, 20'd77, 1'b1, 1'b1);
    recv("post_rst", 4'd3, 8'd77, 8'd77);
    @(posedge clk); #1;
    check_val("post_rst_empty", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
